// File: rtl/question_block_renderer.sv
// Question-block overlay: maps raster coordinates into the 16x16 sprite, runs the hit
// bump animation and composites the masked sprite pixel over the background (3-clk latency).
module question_block_renderer #(
  parameter int unsigned SPR_W       = 16,
  parameter int unsigned SPR_H       = 16,
  parameter int unsigned BUMP_HEIGHT = 6,
  parameter int unsigned BUMP_STEP   = 2,
  parameter int unsigned CW          = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] hcnt,
  input  logic [CW-1:0] vcnt,
  input  logic          frame_tick,
  input  logic          hit,
  input  logic          rearm,
  input  logic [CW-1:0] block_x,
  input  logic [CW-1:0] block_y,
  input  logic [7:0]    bg_r,
  input  logic [7:0]    bg_g,
  input  logic [7:0]    bg_b,
  output logic [CW-1:0] spr_ix,
  output logic [CW-1:0] spr_iy,
  input  logic [7:0]    spr_r,
  input  logic [7:0]    spr_g,
  input  logic [7:0]    spr_b,
  input  logic          spr_mask,
  output logic [7:0]    oR,
  output logic [7:0]    oG,
  output logic [7:0]    oB,
  output logic          busy,
  output logic          used
);

  localparam logic [CW-1:0] BumpHeight = CW'(BUMP_HEIGHT);
  localparam logic [CW-1:0] BumpStep   = CW'(BUMP_STEP);
  localparam logic [CW:0]   SprW       = (CW+1)'(SPR_W);
  localparam logic [CW:0]   SprH       = (CW+1)'(SPR_H);

  typedef enum logic [1:0] {StIdle, StBumpUp, StBumpDown, StUsed} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] offset_q, offset_d;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    case (state_q)
      StIdle: begin
        // A frame_tick coinciding with the hit does not move the block yet.
        if (hit) state_d = StBumpUp;
      end
      StBumpUp: begin
        if (frame_tick) begin
          if (offset_q >= BumpHeight)             state_d  = StBumpDown;
          else if (offset_q + BumpStep >= BumpHeight) offset_d = BumpHeight;
          else                                    offset_d = offset_q + BumpStep;
        end
      end
      StBumpDown: begin
        if (frame_tick) begin
          if (offset_q == '0)             state_d  = StUsed;
          else if (offset_q <= BumpStep)  offset_d = '0;
          else                            offset_d = offset_q - BumpStep;
        end
      end
      StUsed: begin
        if (rearm) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      offset_q <= '0;
      busy     <= 1'b0;
      used     <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      busy     <= (state_d == StBumpUp) || (state_d == StBumpDown);
      used     <= (state_d == StUsed);
    end
  end

  // Window test in CW+1 bits so a block near the right/bottom edge never wraps to column 0.
  logic [CW-1:0] eff_y;
  logic [CW:0]   hx, vy, bx, by;
  logic          in_win;

  always_comb begin
    eff_y  = (offset_q > block_y) ? '0 : block_y - offset_q;
    hx     = {1'b0, hcnt};
    vy     = {1'b0, vcnt};
    bx     = {1'b0, block_x};
    by     = {1'b0, eff_y};
    in_win = (hx >= bx) && (hx < bx + SprW) && (vy >= by) && (vy < by + SprH);
  end

  logic        win1_q, win2_q;
  logic        used1_q, used2_q;
  logic [23:0] bg1_q, bg2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spr_ix  <= '0;
      spr_iy  <= '0;
      win1_q  <= 1'b0;
      win2_q  <= 1'b0;
      used1_q <= 1'b0;
      used2_q <= 1'b0;
      bg1_q   <= '0;
      bg2_q   <= '0;
    end else begin
      spr_ix  <= in_win ? hcnt - block_x : '0;
      spr_iy  <= in_win ? vcnt - eff_y : '0;
      win1_q  <= in_win;
      used1_q <= used;
      bg1_q   <= {bg_r, bg_g, bg_b};
      win2_q  <= win1_q;
      used2_q <= used1_q;
      bg2_q   <= bg1_q;
    end
  end

  // A spent block is drawn at half intensity.
  logic [23:0] pix;

  always_comb begin
    pix = bg2_q;
    if (win2_q && spr_mask) begin
      if (used2_q) pix = {1'b0, spr_r[7:1], 1'b0, spr_g[7:1], 1'b0, spr_b[7:1]};
      else         pix = {spr_r, spr_g, spr_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oR <= '0;
      oG <= '0;
      oB <= '0;
    end else begin
      oR <= pix[23:16];
      oG <= pix[15:8];
      oB <= pix[7:0];
    end
  end

endmodule
